// File: rtl/poly_mul256_parallel_in2.sv
// Negacyclic polynomial multiply-accumulate over Z_8192[x]/(x^256+1).
// The a-polynomial is loaded in full; the s-coefficients are streamed one per cycle.
module poly_mul256_parallel_in2 (
   input  logic        clk,
   input  logic        rst,
   input  logic        acc_clear,
   input  logic        pol_load_coeff4x,
   output logic [6:0]  bram_address_relative,
   input  logic [63:0] pol_64bit_in,
   output logic [7:0]  s_address,
   input  logic [63:0] s_vec_64,
   input  logic        read,
   output logic [63:0] coeff4x_out,
   output logic        pol_mul_done
);

   localparam logic [1:0] LOAD  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] MUL   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state_q,   state_d;
   logic [5:0]    loadCnt_q, loadCnt_d;
   logic [3:0]    wordIdx_q, wordIdx_d;
   logic [3:0]    step_q,    step_d;
   logic [5:0]    readPtr_q, readPtr_d;
   logic [3327:0] aReg_q,    aReg_d;
   logic [63:0]   sWord_q,   sWord_d;
   logic [63:0]   coeff_q,   coeff_d;
   logic          done_q,    done_d;

   logic [12:0]   acc_q [256];
   logic [12:0]   macTerm [256];
   logic [63:0]   sWordCur;
   logic [3:0]    sCoeff;

   // The s-ROM word is only on the bus during the first MUL cycle; later cycles use the latched copy.
   always_comb begin
      sWordCur = (step_q == 4'd0) ? s_vec_64 : sWord_q;
      sCoeff   = sWordCur[{step_q, 2'b00} +: 4];
      for (int i = 0; i < 256; i++) begin
         macTerm[i] = sCoeff[3] ? (13'd0 - (aReg_q[13*i +: 13] * {10'd0, sCoeff[2:0]}))
                                :          (aReg_q[13*i +: 13] * {10'd0, sCoeff[2:0]});
      end
   end

   assign bram_address_relative = (state_q == LOAD && loadCnt_q < 6'd52) ? {1'b0, loadCnt_q} : 7'd0;
   assign s_address             = (state_q == FETCH) ? {4'd0, wordIdx_q} : 8'd0;
   assign coeff4x_out           = coeff_q;
   assign pol_mul_done          = done_q;

   always_comb begin
      state_d   = state_q;
      loadCnt_d = loadCnt_q;
      wordIdx_d = wordIdx_q;
      step_d    = step_q;
      readPtr_d = readPtr_q;
      aReg_d    = aReg_q;
      sWord_d   = sWord_q;
      coeff_d   = coeff_q;
      done_d    = done_q;
      case (state_q)
         LOAD: begin
            // Each word arrives one cycle after its address, so capture lags the counter by one.
            if (loadCnt_q != 6'd0) begin
               aReg_d[{loadCnt_q - 6'd1, 6'd0} +: 64] = pol_64bit_in;
            end
            if (loadCnt_q == 6'd52) begin
               state_d   = FETCH;
               loadCnt_d = 6'd0;
               wordIdx_d = 4'd0;
            end else begin
               loadCnt_d = loadCnt_q + 6'd1;
            end
         end
         FETCH: begin
            state_d = MUL;
            step_d  = 4'd0;
         end
         MUL: begin
            if (step_q == 4'd0) begin
               sWord_d = s_vec_64;
            end
            aReg_d = {aReg_q[3314:0], 13'd0 - aReg_q[3327:3315]};
            if (step_q == 4'd15) begin
               step_d = 4'd0;
               if (wordIdx_q == 4'd15) begin
                  state_d = DONE;
               end else begin
                  wordIdx_d = wordIdx_q + 4'd1;
                  state_d   = FETCH;
               end
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         DONE: begin
            done_d = 1'b1;
            if (pol_load_coeff4x) begin
               readPtr_d = 6'd0;
            end else if (read) begin
               coeff_d = {3'b000, acc_q[{readPtr_q, 2'b11}],
                          3'b000, acc_q[{readPtr_q, 2'b10}],
                          3'b000, acc_q[{readPtr_q, 2'b01}],
                          3'b000, acc_q[{readPtr_q, 2'b00}]};
               readPtr_d = readPtr_q + 6'd1;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         loadCnt_q <= 6'd0;
         wordIdx_q <= 4'd0;
         step_q    <= 4'd0;
         readPtr_q <= 6'd0;
         aReg_q    <= '0;
         sWord_q   <= 64'd0;
         coeff_q   <= 64'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         loadCnt_q <= loadCnt_d;
         wordIdx_q <= wordIdx_d;
         step_q    <= step_d;
         readPtr_q <= readPtr_d;
         aReg_q    <= aReg_d;
         sWord_q   <= sWord_d;
         coeff_q   <= coeff_d;
         done_q    <= done_d;
      end
   end

   // The accumulator deliberately survives rst so back-to-back runs accumulate.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 256; i++) begin
         if (acc_clear) begin
            acc_q[i] <= 13'd0;
         end else if (state_q == MUL) begin
            acc_q[i] <= acc_q[i] + macTerm[i];
         end
      end
   end

endmodule

// File: tb/tb_poly_mul256_parallel_in2.sv
// Directed scoreboard bench: expected readout words come from a schoolbook
// negacyclic product computed here and are queued as each read is issued.
module tb_poly_mul256_parallel_in2;

   logic        clk;
   logic        rst;
   logic        acc_clear;
   logic        pol_load_coeff4x;
   logic [6:0]  bram_address_relative;
   logic [63:0] pol_64bit_in;
   logic [7:0]  s_address;
   logic [63:0] s_vec_64;
   logic        read;
   logic [63:0] coeff4x_out;
   logic        pol_mul_done;

   logic [63:0] polRom [52];
   logic [63:0] sRom [16];
   logic [12:0] modelAcc [256];
   logic [63:0] expQ [$];
   logic [63:0] lastWord;
   int          checks;
   int          errors;

   poly_mul256_parallel_in2 dut (
      .clk                   (clk),
      .rst                   (rst),
      .acc_clear             (acc_clear),
      .pol_load_coeff4x      (pol_load_coeff4x),
      .bram_address_relative (bram_address_relative),
      .pol_64bit_in          (pol_64bit_in),
      .s_address             (s_address),
      .s_vec_64              (s_vec_64),
      .read                  (read),
      .coeff4x_out           (coeff4x_out),
      .pol_mul_done          (pol_mul_done)
   );

   always #5 clk = ~clk;

   // Companion ROMs with one-cycle registered read and zero for out-of-range addresses.
   always @(posedge clk) begin
      pol_64bit_in <= (bram_address_relative < 7'd52) ? polRom[bram_address_relative] : 64'd0;
      s_vec_64     <= (s_address < 8'd16) ? sRom[s_address[3:0]] : 64'd0;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] modelWord(input int r);
      return {3'b000, modelAcc[4*r+3], 3'b000, modelAcc[4*r+2],
              3'b000, modelAcc[4*r+1], 3'b000, modelAcc[4*r]};
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 256; i++) modelAcc[i] = 13'd0;
   endtask

   task automatic computeModel();
      logic [3327:0] polVec;
      logic [12:0]   aC;
      logic [12:0]   prod;
      logic [3:0]    sC;
      for (int k = 0; k < 52; k++) polVec[64*k +: 64] = polRom[k];
      for (int j = 0; j < 256; j++) begin
         sC = sRom[j/16][4*(j%16) +: 4];
         if (sC[2:0] != 3'd0) begin
            for (int i = 0; i < 256; i++) begin
               aC   = polVec[13*i +: 13];
               prod = aC * {10'd0, sC[2:0]};
               if (sC[3]) prod = 13'd0 - prod;
               if (i + j < 256) modelAcc[i+j]     = modelAcc[i+j] + prod;
               else             modelAcc[i+j-256] = modelAcc[i+j-256] - prod;
            end
         end
      end
   endtask

   task automatic setStandardS();
      sRom[0] = 64'hA199_3232_A39B_BB33;
      for (int w = 1; w < 16; w++) begin
         for (int n = 0; n < 16; n++) begin
            sRom[w][4*n +: 4] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 4))};
         end
      end
   endtask

   task automatic setSingleS(input logic [63:0] word0);
      for (int w = 0; w < 16; w++) sRom[w] = 64'd0;
      sRom[0] = word0;
   endtask

   // One full run: reset (optionally clearing), optional mid-run abort, then wait for done.
   task automatic applyStimulus(input bit clearAcc, input int abortAfter);
      int firstDone;
      @(negedge clk);
      rst       = 1'b1;
      acc_clear = clearAcc;
      repeat (3) @(negedge clk);
      checkOutput("rstDone", 64'(pol_mul_done), 64'd0);
      if (clearAcc) clearModel();
      rst       = 1'b0;
      acc_clear = 1'b0;
      if (abortAfter > 0) begin
         repeat (abortAfter) @(negedge clk);
         checkOutput("preAbortDone", 64'(pol_mul_done), 64'd0);
         rst       = 1'b1;
         acc_clear = 1'b1;
         #1;
         checkOutput("abortCoeff", coeff4x_out, 64'd0);
         repeat (3) @(negedge clk);
         checkOutput("abortDone", 64'(pol_mul_done), 64'd0);
         clearModel();
         rst       = 1'b0;
         acc_clear = 1'b0;
      end
      computeModel();
      checkOutput("addrCycle0", 64'(bram_address_relative), 64'd0);
      firstDone = 0;
      for (int cyc = 1; cyc <= 340 && firstDone == 0; cyc++) begin
         @(negedge clk);
         if (pol_mul_done) firstDone = cyc;
         if (cyc == 1) begin
            checkOutput("polWord0", pol_64bit_in, polRom[0]);
            checkOutput("addrCycle1", 64'(bram_address_relative), 64'd1);
         end
         if (cyc == 10) checkOutput("addrCycle10", 64'(bram_address_relative), 64'd10);
         if (cyc == 54) checkOutput("sWord0", s_vec_64, sRom[0]);
         if (cyc == 70) checkOutput("sAddrCycle70", 64'(s_address), 64'd1);
      end
      checkOutput("doneCycle", 64'(firstDone), 64'd326);
   endtask

   task automatic readBack(input int first, input int count);
      for (int k = 0; k < count; k++) begin
         read = 1'b1;
         expQ.push_back(modelWord((first + k) % 64));
         @(negedge clk);
         lastWord = expQ.pop_front();
         checkOutput($sformatf("read%0d", (first + k) % 64), coeff4x_out, lastWord);
      end
      read = 1'b0;
   endtask

   task automatic pointerReset();
      pol_load_coeff4x = 1'b1;
      read             = 1'b1;
      @(negedge clk);
      pol_load_coeff4x = 1'b0;
      read             = 1'b0;
      checkOutput("holdOnPtrReset", coeff4x_out, lastWord);
   endtask

   initial begin
      clk              = 1'b0;
      rst              = 1'b1;
      acc_clear        = 1'b1;
      pol_load_coeff4x = 1'b0;
      read             = 1'b0;
      checks           = 0;
      errors           = 0;
      lastWord         = 64'd0;
      polRom[0] = 64'hED3E_8218_895D_8A50;
      for (int k = 1; k < 52; k++) polRom[k] = {$urandom, $urandom};
      setStandardS();

      $display("[TB] reset with accumulator clear");
      repeat (10) @(negedge clk);
      checkOutput("resetDone", 64'(pol_mul_done), 64'd0);
      checkOutput("resetCoeff", coeff4x_out, 64'd0);
      checkOutput("resetBramAddr", 64'(bram_address_relative), 64'd0);
      checkOutput("resetSAddr", 64'(s_address), 64'd0);

      $display("[TB] standard ROMs");
      applyStimulus(1'b1, 0);
      readBack(0, 64);
      repeat (2) @(negedge clk);
      checkOutput("holdNoRead", coeff4x_out, lastWord);

      $display("[TB] accumulator clear in DONE");
      acc_clear = 1'b1;
      @(negedge clk);
      acc_clear = 1'b0;
      clearModel();
      checkOutput("doneAfterClear", 64'(pol_mul_done), 64'd1);
      pointerReset();
      readBack(0, 2);

      $display("[TB] s = 1");
      setSingleS(64'h1);
      applyStimulus(1'b1, 0);
      readBack(0, 1);
      checkOutput("coeff0", {48'd0, coeff4x_out[15:0]}, 64'h0A50);
      readBack(1, 63);

      $display("[TB] s = 1 again without clear");
      applyStimulus(1'b0, 0);
      readBack(0, 10);
      pointerReset();
      readBack(0, 4);

      $display("[TB] s = -1");
      setSingleS(64'h9);
      applyStimulus(1'b1, 0);
      readBack(0, 64);

      $display("[TB] s = x");
      setSingleS(64'h10);
      applyStimulus(1'b1, 0);
      readBack(0, 64);

      $display("[TB] reset pulse during MUL");
      setStandardS();
      applyStimulus(1'b1, 150);
      readBack(0, 64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/poly_mul256_parallel_in2.md
POLY_MUL256_PARALLEL_IN2 -- requirements
Module: poly_mul256_parallel_in2

Interface
REQ-001 The block SHALL have no parameters; N=256 coefficients, a-coefficients 13 bits (mod 2^13), s-coefficients 4 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 acc_clear  in  1  synchronous accumulator clear.
REQ-006 pol_load_coeff4x  in  1  readout pointer reset to word 0, active in DONE.
REQ-007 bram_address_relative  out  7  word address of polynomial a, valid range 0..51.
REQ-008 pol_64bit_in  in  64  a-word returned by external ROM/BRAM, 1-cycle read latency.
REQ-009 s_address  out  8  word address of secret s, valid range 0..15.
REQ-010 s_vec_64  in  64  s-word returned by external ROM, 1-cycle read latency.
REQ-011 read  in  1  readout advance enable.
REQ-012 coeff4x_out  out  64  four result coefficients, each zero-extended to 16 bits.
REQ-013 pol_mul_done  out  1  result valid, level.
REQ-014 Companion models pol_rom (clk, bram_address_relative[6:0] -> pol_64bit_in[63:0], 52 words) and s_rom (clk, s_address[7:0] -> s_vec_64[63:0], 16 words) SHALL register output on posedge, returning 0 for out-of-range addresses.

Function
REQ-015 Packing: a coefficient i = bits [13i+12:13i] of the 3328-bit concatenation of words 0..51 (word k at [64k+63:64k]); s coefficient j = bits [4(j%16)+3:4(j%16)] of word j/16.
REQ-016 s coefficients SHALL be sign-magnitude: bit3 sign, bits2:0 magnitude (0..4); 4'b1000 equals 0.
REQ-017 Result SHALL be acc = acc_prev + a*s in Z_8192[x]/(x^256+1), all arithmetic mod 2^13.
REQ-018 FSM states LOAD, FETCH, MUL, DONE; LOAD entered on reset release.
REQ-019 LOAD: drives addresses 0..51 on consecutive cycles, captures each word one cycle later into 3328-bit a-register; lasts exactly 53 cycles.
REQ-020 FETCH: one cycle driving s_address=w (w=0..15); MUL: 16 cycles using the latched word, coefficient j=16w+t in cycle t.
REQ-021 Each MUL cycle: acc[i] += (sign ? -a[i]*mag : a[i]*mag) for all 256 i in parallel, then a <= a*x mod (x^256+1): a[0] <= -a[255] mod 8192, a[i] <= a[i-1].
REQ-022 After w=15 MUL ends, FSM SHALL enter DONE; pol_mul_done first high on cycle 326 after reset release (cycle 1 = first posedge with rst low), stays high until rst.
REQ-023 DONE readout: read=1 -> coeff4x_out <= {acc[4r+3],acc[4r+2],acc[4r+1],acc[4r]} (each 3'b0 & 13 bits), r <= r+1, wrapping 63->0; read=0 -> holds.
REQ-024 pol_load_coeff4x=1 in DONE SHALL set r=0, priority over read; ignored elsewhere.
REQ-025 coeff4x_out SHALL be 0 outside DONE; address outputs SHALL hold 0 outside LOAD/FETCH.
REQ-026 acc_clear=1 SHALL zero all 256 accumulator coefficients on the next edge in any state, priority over MAC update; FSM unaffected.
REQ-027 The accumulator SHALL NOT be cleared by rst, so rst with acc_clear=0 performs multiply-accumulate onto the previous result.

Reset
REQ-028 rst=1 SHALL immediately force LOAD at word 0, all counters 0, a-register 0, pol_mul_done=0, coeff4x_out=0, both addresses 0; assertion mid-operation aborts and restarts on release.
REQ-029 Accumulator content after power-up is undefined until acc_clear is applied.

Verification
REQ-030 rst=1, acc_clear=1 for 10 cycles -> pol_mul_done=0, coeff4x_out=0, addresses 0; after release with a clock edge, acc all zero.
REQ-031 Standard ROMs: pol_rom word0 = 64'hED3E_8218_895D_8A50, s_rom word0 = 64'hA199_3232_A39B_BB33, each appearing one cycle after address 0; pol_mul_done rises exactly on cycle 326.
REQ-032 s word0=64'h1, others 0 -> 64 read cycles return a unchanged (coefficient 0 = 13'h0A50 first); s word0=64'h9 -> each coefficient = (8192-a[i]) mod 8192.
REQ-033 s word0=64'h10 (s_1=1) -> acc[0] = -a[255] mod 8192, acc[i] = a[i-1].
REQ-034 Repeat REQ-032 with s=1 via rst only (acc_clear=0) -> results 2*a[i] mod 8192; pol_load_coeff4x pulse mid-readout -> next read returns coefficients 0..3.
REQ-035 rst pulse during MUL -> done stays low, restart, done on cycle 326 after release.
